id_ex_register: RTL

Decode-to-execute pipeline register of the 5-stage RV32I core. It captures decode-stage operands, immediate, PC values, register indices and the packed control word. It presents them, one cycle later, to the execute stage. Its RD2E/ImmExtE/ALUSrc outputs feed the SrcB operand mux directly. It supports hazard-unit stall (hold) and flush (bubble insert), tracks a valid bit, and keeps a saturating bubble counter for performance debug.

---
 rtl/riscv_pipe_pkg.sv | 19 +
 rtl/pipe_reg_en_clr.sv | 34 +++
 rtl/id_ex_register.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RV32I core: control word layout and NOP encoding.
package riscv_pipe_pkg;

    localparam int CTRL_W = 10;

    // Bit positions inside the packed control word
    localparam int CTRL_REGWRITE     = 9;
    localparam int CTRL_RESULTSRC_HI = 8;
    localparam int CTRL_RESULTSRC_LO = 7;
    localparam int CTRL_MEMWRITE     = 6;
    localparam int CTRL_JUMP         = 5;
    localparam int CTRL_BRANCH       = 4;
    localparam int CTRL_ALUCTRL_HI   = 3;
    localparam int CTRL_ALUCTRL_LO   = 1;
    localparam int CTRL_ALUSRC       = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with load enable and synchronous clear; 1-cycle latency.
// Holds when en=0; clr only takes effect on an enabled edge, reset always wins.
module pipe_reg_en_clr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? '0 : d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and a saturating bubble counter.
// 1-cycle latency when loading; StallE holds everything, FlushE overrides StallE.
module id_ex_register
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [CNT_W-1:0]  BubbleCount
);

    localparam int DATA_W = 5 * XLEN;
    localparam int IDX_W  = 3 * REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stage_en;
    logic stage_clr;
    logic bubble_load;

    // Flush must beat stall, and an invalid decode slot is loaded as a bubble
    // so ValidE=0 always comes with NOP control and RdE=0.
    assign stage_en    = ~StallE | FlushE;
    assign stage_clr   = FlushE | ~ValidD;
    assign bubble_load = stage_en & stage_clr;

    pipe_reg_en_clr #(.W(1)) u_valid (
        .clk   (clk),
        .reset (reset),
        .en    (stage_en),
        .clr   (stage_clr),
        .d     (ValidD),
        .q     (ValidE)
    );

    pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .en    (stage_en),
        .clr   (stage_clr),
        .d     (CtrlD),
        .q     (CtrlE)
    );

    pipe_reg_en_clr #(.W(DATA_W)) u_data (
        .clk   (clk),
        .reset (reset),
        .en    (stage_en),
        .clr   (stage_clr),
        .d     ({RD1D, RD2D, ImmExtD, PCD, PCPlus4D}),
        .q     ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E})
    );

    pipe_reg_en_clr #(.W(IDX_W)) u_idx (
        .clk   (clk),
        .reset (reset),
        .en    (stage_en),
        .clr   (stage_clr),
        .d     ({Rs1D, Rs2D, RdD}),
        .q     ({Rs1E, Rs2E, RdE})
    );

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;

endmodule
